// File: rtl/ahb_cfg_master.sv
// rtl/ahb_cfg_master.sv - AHB initiator programming the RC4/edge-detect slave (optional CFG_TIMEOUT_EN watchdog)
module ahb_cfg_master #(
    parameter logic [3:0]  SLAVE_SEL   = 4'b1010,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        cfg_start,
    input  logic [19:0] cfg_img_addr,
    input  logic [31:0] cfg_key,
    input  logic [11:0] cfg_width,
    input  logic [11:0] cfg_height,
    input  logic        proc_done,
    input  logic        proc_error,
    output logic [31:0] HADDR,
    output logic [1:0]  HSIZE,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic        HRESP,
    input  logic [31:0] HRDATA,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code,
    output logic        err_rd
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_ADDR, S_WR_DATA, S_WAIT_PROC, S_RD_ADDR, S_RD_DATA, S_FINISH
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [19:0] img_addr_q, img_addr_d;
    logic [31:0] key_q, key_d;
    logic [11:0] width_q, width_d;
    logic [11:0] height_q, height_d;
    logic [1:0]  err_code_q, err_code_d;
    logic        err_rd_q, err_rd_d;
    logic [3:0]  wr_off;

`ifdef CFG_TIMEOUT_EN
    logic [31:0] wdog_q, wdog_d;
`else
    logic [31:0] timeout_unused;
    assign timeout_unused = 32'(TIMEOUT_CYC);
`endif

    // Only bit 0 of the error register carries information.
    logic [30:0] hrdata_unused;
    assign hrdata_unused = HRDATA[31:1];

    assign wr_off   = 4'b0001 << idx_q;
    assign busy     = (state_q != S_IDLE);
    assign err_code = err_code_q;
    assign err_rd   = err_rd_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        img_addr_d = img_addr_q;
        key_d      = key_q;
        width_d    = width_q;
        height_d   = height_q;
        err_code_d = err_code_q;
        err_rd_d   = err_rd_q;
`ifdef CFG_TIMEOUT_EN
        wdog_d     = wdog_q;
`endif
        HADDR      = 32'h0;
        HSIZE      = 2'b00;
        HWRITE     = 1'b0;
        HWDATA     = 32'h0;
        done       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    img_addr_d = cfg_img_addr;
                    key_d      = cfg_key;
                    width_d    = cfg_width;
                    height_d   = cfg_height;
                    err_code_d = 2'b00;
                    err_rd_d   = 1'b0;
                    idx_d      = 2'd0;
                    state_d    = S_WR_ADDR;
                end
            end
            S_WR_ADDR: begin
                HADDR  = {SLAVE_SEL, 24'h0, wr_off};
                HWRITE = 1'b1;
                HSIZE  = 2'b10;
                if (HRESP) begin
                    err_code_d = 2'b10;
                    state_d    = S_FINISH;
                end else begin
                    state_d = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                case (idx_q)
                    2'd0:    HWDATA = {12'h0, img_addr_q};
                    2'd1:    HWDATA = key_q;
                    2'd2:    HWDATA = {20'h0, width_q};
                    default: HWDATA = {20'h0, height_q};
                endcase
                if (HRESP) begin
                    err_code_d = 2'b10;
                    state_d    = S_FINISH;
                end else if (idx_q == 2'd3) begin
                    state_d = S_WAIT_PROC;
`ifdef CFG_TIMEOUT_EN
                    wdog_d  = 32'h0;
`endif
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_WR_ADDR;
                end
            end
            S_WAIT_PROC: begin
                // Completion outranks error, and both outrank the watchdog.
                if (proc_done) begin
                    err_code_d = 2'b00;
                    state_d    = S_FINISH;
                end else if (proc_error) begin
                    state_d = S_RD_ADDR;
                end
`ifdef CFG_TIMEOUT_EN
                else if (wdog_q == 32'(TIMEOUT_CYC - 1)) begin
                    err_code_d = 2'b11;
                    state_d    = S_FINISH;
                end else begin
                    wdog_d = wdog_q + 32'd1;
                end
`endif
            end
            S_RD_ADDR: begin
                HADDR = {SLAVE_SEL, 24'h0, 4'hF};
                HSIZE = 2'b10;
                if (HRESP) begin
                    err_code_d = 2'b10;
                    state_d    = S_FINISH;
                end else begin
                    state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (HRESP) begin
                    err_code_d = 2'b10;
                end else begin
                    err_rd_d   = HRDATA[0];
                    err_code_d = 2'b01;
                end
                state_d = S_FINISH;
            end
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= S_IDLE;
            idx_q      <= 2'd0;
            img_addr_q <= 20'h0;
            key_q      <= 32'h0;
            width_q    <= 12'h0;
            height_q   <= 12'h0;
            err_code_q <= 2'b00;
            err_rd_q   <= 1'b0;
`ifdef CFG_TIMEOUT_EN
            wdog_q     <= 32'h0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            img_addr_q <= img_addr_d;
            key_q      <= key_d;
            width_q    <= width_d;
            height_q   <= height_d;
            err_code_q <= err_code_d;
            err_rd_q   <= err_rd_d;
`ifdef CFG_TIMEOUT_EN
            wdog_q     <= wdog_d;
`endif
        end
    end

endmodule

// File: tb/tb_ahb_cfg_master.sv
// tb/tb_ahb_cfg_master.sv - directed self-checking bench for ahb_cfg_master
module tb_ahb_cfg_master;
    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        cfg_start = 1'b0;
    logic [19:0] cfg_img_addr = 20'h0;
    logic [31:0] cfg_key = 32'h0;
    logic [11:0] cfg_width = 12'h0;
    logic [11:0] cfg_height = 12'h0;
    logic        proc_done = 1'b0;
    logic        proc_error = 1'b0;
    logic [31:0] HADDR;
    logic [1:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HRESP = 1'b0;
    logic [31:0] HRDATA = 32'h0;
    logic        busy;
    logic        done;
    logic [1:0]  err_code;
    logic        err_rd;

    int checks = 0;
    int fails  = 0;

    ahb_cfg_master #(.SLAVE_SEL(4'b1010), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .n_rst(n_rst), .cfg_start(cfg_start), .cfg_img_addr(cfg_img_addr),
        .cfg_key(cfg_key), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .proc_done(proc_done), .proc_error(proc_error), .HADDR(HADDR), .HSIZE(HSIZE),
        .HWRITE(HWRITE), .HWDATA(HWDATA), .HRESP(HRESP), .HRDATA(HRDATA),
        .busy(busy), .done(done), .err_code(err_code), .err_rd(err_rd)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issues cfg_start in the current cycle (cycle 0); returns in cycle 1.
    task automatic start_seq(input logic [19:0] a, input logic [31:0] k,
                             input logic [11:0] w, input logic [11:0] h);
        cfg_img_addr = a; cfg_key = k; cfg_width = w; cfg_height = h;
        cfg_start = 1'b1;
        next_cycle();
        cfg_start = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if ({HADDR, HSIZE, HWRITE, HWDATA, busy, done, err_code, err_rd} !== 73'h0) begin
            fails++; $display("FAIL reset_outputs got haddr=%h hsize=%b hwrite=%b hwdata=%h busy=%b done=%b err=%b err_rd=%b exp all 0",
                              HADDR, HSIZE, HWRITE, HWDATA, busy, done, err_code, err_rd); end
        next_cycle();
        n_rst = 1'b1;
        next_cycle();
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_happy();
        logic [31:0] wdat[4];
        logic [31:0] ea, ed;
        logic        ew;
        logic [1:0]  es;
        int          early_done;
        wdat[0] = 32'h0001_2345; wdat[1] = 32'hDEAD_BEEF; wdat[2] = 32'h0000_0280; wdat[3] = 32'h0000_01E0;
        start_seq(20'h12345, 32'hDEADBEEF, 12'd640, 12'd480);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c % 2 == 1) begin
                ea = 32'hA000_0000 | (32'h1 << ((c - 1) / 2)); ew = 1'b1; es = 2'b10; ed = 32'h0;
            end else begin
                ea = 32'h0; ew = 1'b0; es = 2'b00; ed = wdat[(c - 2) / 2];
            end
            checks++; if ({HADDR, HWRITE, HSIZE, HWDATA} !== {ea, ew, es, ed}) begin
                fails++; $display("FAIL happy_bus c%0d got haddr=%h hwrite=%b hsize=%b hwdata=%h exp %h %b %b %h",
                                  c, HADDR, HWRITE, HSIZE, HWDATA, ea, ew, es, ed); end
            checks++; if (busy !== 1'b1) begin fails++; $display("FAIL happy_busy c%0d got %b exp 1", c, busy); end
            next_cycle();
        end
        early_done = 0;
        for (int c = 9; c < 20; c++) begin
            @(negedge clk);
            if (done !== 1'b0 || HADDR !== 32'h0) early_done++;
            next_cycle();
        end
        checks++; if (early_done !== 0) begin fails++; $display("FAIL happy_wait_idle got %0d bad cycles exp 0", early_done); end
        proc_done = 1'b1;
        next_cycle();
        proc_done = 1'b0;
        @(negedge clk);
        checks++; if ({done, err_code, busy} !== {1'b1, 2'b00, 1'b1}) begin
            fails++; $display("FAIL happy_done c21 got done=%b err=%b busy=%b exp 1 00 1", done, err_code, busy); end
        next_cycle();
        @(negedge clk);
        checks++; if ({done, busy} !== 2'b00) begin
            fails++; $display("FAIL happy_idle c22 got done=%b busy=%b exp 0 0", done, busy); end
    endtask

    task automatic test_proc_error();
        start_seq(20'h00001, 32'h0000_0002, 12'd3, 12'd4);
        repeat (14) next_cycle();
        proc_error = 1'b1;
        next_cycle();
        proc_error = 1'b0;
        @(negedge clk);
        checks++; if ({HADDR, HWRITE, HSIZE} !== {32'hA000_000F, 1'b0, 2'b10}) begin
            fails++; $display("FAIL perr_rd_addr c16 got haddr=%h hwrite=%b hsize=%b exp a000000f 0 10", HADDR, HWRITE, HSIZE); end
        next_cycle();
        HRDATA = 32'h0000_0001;
        @(negedge clk);
        checks++; if (HADDR !== 32'h0) begin fails++; $display("FAIL perr_rd_data_idle c17 got %h exp 0", HADDR); end
        next_cycle();
        HRDATA = 32'h0;
        @(negedge clk);
        checks++; if ({done, err_code, err_rd} !== {1'b1, 2'b01, 1'b1}) begin
            fails++; $display("FAIL perr_done c18 got done=%b err=%b err_rd=%b exp 1 01 1", done, err_code, err_rd); end
        next_cycle();
    endtask

    task automatic test_bus_error();
        int n_done, n_wr;
        start_seq(20'hABCDE, 32'h0BAD_F00D, 12'd7, 12'd9);
        @(negedge clk);
        checks++; if ({err_code, err_rd} !== 3'b000) begin
            fails++; $display("FAIL berr_clear c1 got err=%b err_rd=%b exp 00 0", err_code, err_rd); end
        repeat (4) next_cycle();
        HRESP = 1'b1;
        @(negedge clk);
        checks++; if (HADDR !== 32'hA000_0004) begin fails++; $display("FAIL berr_third_addr c5 got %h exp a0000004", HADDR); end
        next_cycle();
        HRESP = 1'b0;
        @(negedge clk);
        checks++; if ({done, err_code, HWRITE, HADDR} !== {1'b1, 2'b10, 1'b0, 32'h0}) begin
            fails++; $display("FAIL berr_done c6 got done=%b err=%b hwrite=%b haddr=%h exp 1 10 0 0", done, err_code, HWRITE, HADDR); end
        n_done = 0; n_wr = 0;
        for (int c = 7; c < 15; c++) begin
            next_cycle();
            @(negedge clk);
            if (done === 1'b1) n_done++;
            if (HWRITE === 1'b1) n_wr++;
        end
        checks++; if ({n_done, n_wr} !== {32'd0, 32'd0}) begin
            fails++; $display("FAIL berr_no_more got extra_done=%0d writes=%0d exp 0 0", n_done, n_wr); end
        next_cycle();
    endtask

    task automatic test_busy_priority();
        int n_rd;
        start_seq(20'h00ABC, 32'h1111_2222, 12'd5, 12'd6);
        next_cycle();
        cfg_key = 32'hFFFF_0000; cfg_width = 12'd99; cfg_start = 1'b1;
        next_cycle();
        cfg_start = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++; if (HWDATA !== 32'h1111_2222) begin fails++; $display("FAIL busy_key c4 got %h exp 11112222", HWDATA); end
        next_cycle(); next_cycle();
        @(negedge clk);
        checks++; if (HWDATA !== 32'h0000_0005) begin fails++; $display("FAIL busy_width c6 got %h exp 00000005", HWDATA); end
        repeat (4) next_cycle();
        proc_done = 1'b1; proc_error = 1'b1;
        next_cycle();
        proc_done = 1'b0; proc_error = 1'b0;
        @(negedge clk);
        checks++; if ({done, err_code, HADDR} !== {1'b1, 2'b00, 32'h0}) begin
            fails++; $display("FAIL prio_done c11 got done=%b err=%b haddr=%h exp 1 00 0", done, err_code, HADDR); end
        n_rd = 0;
        for (int c = 12; c < 16; c++) begin
            next_cycle();
            @(negedge clk);
            if (HADDR !== 32'h0 || busy !== 1'b0) n_rd++;
        end
        checks++; if (n_rd !== 0) begin fails++; $display("FAIL prio_no_read got %0d bus cycles exp 0", n_rd); end
        next_cycle();
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] ea, ed;
        logic [31:0] wdat[4];
        wdat[0] = 32'h0007_7777; wdat[1] = 32'hCAFE_0001; wdat[2] = 32'h0000_0010; wdat[3] = 32'h0000_0020;
        start_seq(20'h55555, 32'h5A5A_5A5A, 12'd1, 12'd2);
        repeat (3) next_cycle();
        n_rst = 1'b0;
        #1;
        checks++; if ({HADDR, HWDATA, HSIZE, HWRITE, busy, done, err_code} !== 71'h0) begin
            fails++; $display("FAIL rst_mid_outputs got haddr=%h hwdata=%h hsize=%b hwrite=%b busy=%b done=%b err=%b exp all 0",
                              HADDR, HWDATA, HSIZE, HWRITE, busy, done, err_code); end
        next_cycle();
        n_rst = 1'b1;
        next_cycle();
        start_seq(20'h77777, 32'hCAFE_0001, 12'd16, 12'd32);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            ea = (c % 2 == 1) ? (32'hA000_0000 | (32'h1 << ((c - 1) / 2))) : 32'h0;
            ed = (c % 2 == 0) ? wdat[(c - 2) / 2] : 32'h0;
            checks++; if ({HADDR, HWDATA} !== {ea, ed}) begin
                fails++; $display("FAIL rst_rerun c%0d got haddr=%h hwdata=%h exp %h %h", c, HADDR, HWDATA, ea, ed); end
            next_cycle();
        end
        proc_done = 1'b1;
        next_cycle();
        proc_done = 1'b0;
        @(negedge clk);
        checks++; if ({done, err_code} !== 3'b100) begin
            fails++; $display("FAIL rst_rerun_done got done=%b err=%b exp 1 00", done, err_code); end
        next_cycle();
    endtask

    task automatic test_timeout();
        int bad;
        start_seq(20'h00002, 32'h0000_0003, 12'd4, 12'd5);
        repeat (8) next_cycle();
`ifdef CFG_TIMEOUT_EN
        bad = 0;
        for (int c = 9; c < 25; c++) begin
            @(negedge clk);
            if (done !== 1'b0) bad++;
            next_cycle();
        end
        checks++; if (bad !== 0) begin fails++; $display("FAIL tmo_early got %0d done cycles exp 0", bad); end
        @(negedge clk);
        checks++; if ({done, err_code} !== 3'b111) begin
            fails++; $display("FAIL tmo_done c25 got done=%b err=%b exp 1 11", done, err_code); end
        next_cycle();
`else
        bad = 0;
        for (int c = 9; c < 60; c++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b1 || HADDR !== 32'h0) bad++;
            next_cycle();
        end
        checks++; if (bad !== 0) begin fails++; $display("FAIL wait_forever got %0d bad cycles exp 0", bad); end
        proc_done = 1'b1;
        next_cycle();
        proc_done = 1'b0;
        @(negedge clk);
        checks++; if ({done, err_code} !== 3'b100) begin
            fails++; $display("FAIL wait_forever_done got done=%b err=%b exp 1 00", done, err_code); end
        next_cycle();
`endif
    endtask

    initial begin
        test_reset();
        test_happy();
        next_cycle();
        test_proc_error();
        test_bus_error();
        test_busy_priority();
        test_reset_mid_write();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
